// File: rtl/multicycle_controller_if.sv
// Bundles the instruction/run-control inputs and the decoded/gated outputs of the
// multicycle controller.
//   master: drives start, opcode, branch_bits; observes decode, strobes and status
//   slave : the controller side (inverse directions)
interface multicycle_controller_if #(
  parameter int unsigned NUM_PROG = 3,
  parameter int unsigned PROG_W   = $clog2(NUM_PROG > 1 ? NUM_PROG : 2)
);
  logic              start;
  logic [2:0]        opcode;
  logic [1:0]        branch_bits;
  logic              wr_en;
  logic              mem_write;
  logic              pc_en;
  logic              sub;
  logic              alu_src;
  logic              shift_left;
  logic              use_lut;
  logic              branch;
  logic              sel_rd;
  logic              alu_mem_sel;
  logic              next_branch_selector;
  logic [1:0]        alu_op;
  logic [1:0]        branch_sel;
  logic [1:0]        sel_rs;
  logic              busy;
  logic              done;
  logic              all_done;
  logic [PROG_W-1:0] prog_idx;

  modport master (
    output start, opcode, branch_bits,
    input  wr_en, mem_write, pc_en, sub, alu_src, shift_left, use_lut, branch, sel_rd,
           alu_mem_sel, next_branch_selector, alu_op, branch_sel, sel_rs, busy, done,
           all_done, prog_idx
  );

  modport slave (
    input  start, opcode, branch_bits,
    output wr_en, mem_write, pc_en, sub, alu_src, shift_left, use_lut, branch, sel_rd,
           alu_mem_sel, next_branch_selector, alu_op, branch_sel, sel_rs, busy, done,
           all_done, prog_idx
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle controller: decodes {opcode, branch_bits} combinationally and sequences
// execution through IDLE/RUN/MEM/HALT. Side-effect strobes (wr_en, mem_write, pc_en)
// are only raised in RUN/MEM. Memory ops are stretched to MEM_LAT cycles and NUM_PROG
// programs run back to back, one start pulse each.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of multicycle_controller_if (instruction in, decode/strobes out)
module multicycle_controller #(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned NUM_PROG = 3,
  parameter int unsigned PROG_W   = $clog2(NUM_PROG > 1 ? NUM_PROG : 2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.slave   bus
);

  localparam int unsigned CntW = $clog2(MEM_LAT > 1 ? MEM_LAT : 2);
  localparam logic [CntW-1:0]   CntLoad  = CntW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
  localparam logic [PROG_W-1:0] LastProg = PROG_W'(NUM_PROG - 1);

  typedef enum logic [1:0] {StIdle, StRun, StMem, StHalt} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PROG_W-1:0] prog_q, prog_d;
  logic              all_done_q, all_done_d;

  logic [2:0] op;
  logic [1:0] bb;
  logic       is_hlt, is_memop, is_wr;
  logic       wr_en, mem_write, pc_en;

  assign op = bus.opcode;
  assign bb = bus.branch_bits;

  // Ungated decode
  assign bus.sub                  = (op == 3'b010) & ~bb[1];
  assign bus.alu_src              = (op[2:1] == 2'b00);
  assign bus.sel_rd               = (op[2:1] == 2'b00);
  assign bus.shift_left           = bb[1];
  assign bus.use_lut              = bb[0];
  assign bus.branch               = (op == 3'b010);
  assign bus.alu_mem_sel          = (op == 3'b011) & ~bb[1];
  assign bus.next_branch_selector = ((op == 3'b010) & (bb != 2'b11)) | (op == 3'b001);
  assign bus.branch_sel           = bb;

  always_comb begin
    bus.alu_op = 2'b00;
    unique case (op)
      3'b101:  bus.alu_op = 2'b01;
      3'b110:  bus.alu_op = 2'b10;
      3'b100:  bus.alu_op = 2'b11;
      default: bus.alu_op = 2'b00;
    endcase
  end

  always_comb begin
    bus.sel_rs = 2'b00;
    unique case (op)
      3'b100:                 bus.sel_rs = 2'b01;
      3'b101, 3'b110, 3'b111: bus.sel_rs = 2'b00;
      3'b010, 3'b011:         bus.sel_rs = 2'b10;
      default:                bus.sel_rs = 2'b11;
    endcase
  end

  // Instruction classes
  assign is_hlt   = (op == 3'b011) & (bb == 2'b11);
  assign is_memop = (op == 3'b011) & (bb != 2'b11);
  assign is_wr    = op[2] | (op == 3'b000) | (op == 3'b001) | (is_memop & ~bb[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prog_q     <= '0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prog_q     <= prog_d;
      all_done_q <= all_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prog_d     = prog_q;
    all_done_d = all_done_q;
    wr_en      = 1'b0;
    mem_write  = 1'b0;
    pc_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        if (is_hlt) begin
          state_d = StHalt;
          if (prog_q == LastProg) all_done_d = 1'b1;
        end else if (is_memop) begin
          mem_write = (bb == 2'b10);
          if (MEM_LAT == 1) begin
            pc_en = 1'b1;
            wr_en = is_wr;
          end else begin
            // Issue cycle; the PC stays frozen so the instruction is held through MEM
            cnt_d   = CntLoad;
            state_d = StMem;
          end
        end else begin
          pc_en = 1'b1;
          wr_en = is_wr;
        end
      end
      StMem: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          pc_en   = 1'b1;
          wr_en   = is_wr;
          state_d = StRun;
        end
      end
      StHalt: begin
        if (bus.start) begin
          state_d = StRun;
          if (prog_q == LastProg) begin
            prog_d     = '0;
            all_done_d = 1'b0;
          end else begin
            prog_d = prog_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // No side effects while reset is being applied, even mid-MEM
    if (!rst_n) begin
      wr_en     = 1'b0;
      mem_write = 1'b0;
      pc_en     = 1'b0;
    end
  end

  assign bus.wr_en     = wr_en;
  assign bus.mem_write = mem_write;
  assign bus.pc_en     = pc_en;
  assign bus.busy      = (state_q == StRun) | (state_q == StMem);
  assign bus.done      = (state_q == StHalt);
  assign bus.all_done  = all_done_q;
  assign bus.prog_idx  = prog_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int unsigned MemLat  = 3;
  localparam int unsigned NumProg = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  multicycle_controller_if #(.NUM_PROG(NumProg)) mc_if ();

  multicycle_controller #(
    .MEM_LAT (MemLat),
    .NUM_PROG(NumProg)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic st, input logic [2:0] op, input logic [1:0] bb);
    mc_if.start       = st;
    mc_if.opcode      = op;
    mc_if.branch_bits = bb;
    #1;
  endtask

  // {wr_en, mem_write, pc_en}
  function automatic logic [2:0] strobes();
    return {mc_if.wr_en, mc_if.mem_write, mc_if.pc_en};
  endfunction

  // {sub, alu_src, shift_left, use_lut, branch, sel_rd, alu_mem_sel, nbs,
  //  alu_op, branch_sel, sel_rs}
  function automatic logic [13:0] dec_obs();
    return {mc_if.sub, mc_if.alu_src, mc_if.shift_left, mc_if.use_lut, mc_if.branch,
            mc_if.sel_rd, mc_if.alu_mem_sel, mc_if.next_branch_selector, mc_if.alu_op,
            mc_if.branch_sel, mc_if.sel_rs};
  endfunction

  // Per-opcode hand-derived fields: {sub_if_bb1_0, alu_src/sel_rd, branch, ams_if_bb1_0,
  //  nbs_if_bb_not_11, nbs_always, alu_op, sel_rs}
  logic [9:0] op_tab [8] = '{
    10'b0_1_0_0_0_0_00_11,  // 000
    10'b0_1_0_0_0_1_00_11,  // 001
    10'b1_0_1_0_1_0_00_10,  // 010
    10'b0_0_0_1_0_0_00_10,  // 011
    10'b0_0_0_0_0_0_11_01,  // 100
    10'b0_0_0_0_0_0_01_00,  // 101
    10'b0_0_0_0_0_0_10_00,  // 110
    10'b0_0_0_0_0_0_00_00   // 111
  };

  initial begin
    logic [9:0]  row;
    logic [13:0] exp_dec;
    logic [2:0]  exp_stb;
    logic [2:0]  op;
    logic [1:0]  bb;
    logic        wr;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_ins(1'b0, 3'b000, 2'b00);

    // T1: reset
    cyc();
    cyc();
    check("rst_strobes", 32'(strobes()), 32'd0);
    check("rst_done", 32'(mc_if.done), 32'd0);
    check("rst_busy", 32'(mc_if.busy), 32'd0);
    check("rst_all_done", 32'(mc_if.all_done), 32'd0);
    check("rst_prog_idx", 32'(mc_if.prog_idx), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("idle_strobes", 32'(strobes()), 32'd0);
    set_ins(1'b1, 3'b000, 2'b00);
    check("idle_start_no_pc", 32'(strobes()), 32'd0);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);
    check("run_busy", 32'(mc_if.busy), 32'd1);
    check("run_first_pc", 32'(strobes()), 32'b101);
    check("run_prog0", 32'(mc_if.prog_idx), 32'd0);

    // T2: decode sweep within one RUN cycle (no edge while sweeping)
    for (int i = 0; i < 32; i++) begin
      op  = 3'(i >> 2);
      bb  = 2'(i);
      set_ins(1'b0, op, bb);
      row = op_tab[op];
      exp_dec = {row[9] & ~bb[1], row[8], bb[1], bb[0], row[7], row[8], row[6] & ~bb[1],
                 (row[5] & (bb != 2'b11)) | row[4], row[3:2], bb, row[1:0]};
      check($sformatf("dec_%03b_%02b", op, bb), 32'(dec_obs()), 32'(exp_dec));
      wr = op[2] | (op == 3'b000) | (op == 3'b001) | ((op == 3'b011) & ~bb[1]);
      if (op == 3'b011 && bb == 2'b11)  exp_stb = 3'b000;
      else if (op == 3'b011)            exp_stb = {1'b0, bb == 2'b10, 1'b0};
      else                              exp_stb = {wr, 1'b0, 1'b1};
      check($sformatf("stb_%03b_%02b", op, bb), 32'(strobes()), 32'(exp_stb));
    end
    set_ins(1'b0, 3'b100, 2'b10);
    check("dec_100_aluop", 32'(mc_if.alu_op), 32'd3);
    check("dec_100_selrs", 32'(mc_if.sel_rs), 32'd1);
    set_ins(1'b0, 3'b000, 2'b00);

    // T3: store, MEM_LAT=3
    cyc();
    set_ins(1'b0, 3'b011, 2'b10);
    check("st_c1", 32'(strobes()), 32'b010);
    cyc();
    check("st_c2", 32'(strobes()), 32'b000);
    check("st_c2_busy", 32'(mc_if.busy), 32'd1);
    cyc();
    check("st_c3", 32'(strobes()), 32'b001);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);
    check("st_back_run", 32'(strobes()), 32'b101);
    // Load
    cyc();
    set_ins(1'b0, 3'b011, 2'b00);
    check("ld_c1", 32'(strobes()), 32'b000);
    cyc();
    check("ld_c2", 32'(strobes()), 32'b000);
    cyc();
    check("ld_c3", 32'(strobes()), 32'b101);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);

    // T5a: start in RUN ignored
    set_ins(1'b1, 3'b000, 2'b00);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);
    check("start_in_run_prog", 32'(mc_if.prog_idx), 32'd0);
    check("start_in_run_busy", 32'(mc_if.busy), 32'd1);

    // T4: program 0 halts
    set_ins(1'b0, 3'b011, 2'b11);
    check("hlt_strobes", 32'(strobes()), 32'd0);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);
    check("halt0_done", 32'(mc_if.done), 32'd1);
    check("halt0_strobes", 32'(strobes()), 32'd0);
    check("halt0_all_done", 32'(mc_if.all_done), 32'd0);
    set_ins(1'b1, 3'b000, 2'b00);
    check("halt_start_no_pc", 32'(strobes()), 32'd0);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);
    check("prog1_idx", 32'(mc_if.prog_idx), 32'd1);
    check("prog1_pc", 32'(strobes()), 32'b101);

    // T5b: start during MEM ignored
    set_ins(1'b0, 3'b011, 2'b00);
    cyc();
    set_ins(1'b1, 3'b011, 2'b00);
    check("mem_start_strobes", 32'(strobes()), 32'd0);
    cyc();
    set_ins(1'b0, 3'b011, 2'b00);
    check("mem_start_prog", 32'(mc_if.prog_idx), 32'd1);
    check("mem_start_ld", 32'(strobes()), 32'b101);
    cyc();
    set_ins(1'b0, 3'b011, 2'b11);
    cyc();
    set_ins(1'b0, 3'b000, 2'b00);
    check("halt1_done", 32'(mc_if.done), 32'd1);
    check("halt1_prog", 32'(mc_if.prog_idx), 32'd1);
    check("halt1_all_done", 32'(mc_if.all_done), 32'd0);
    set_ins(1'b1, 3'b000, 2'b00);
    cyc();
    set_ins(1'b0, 3'b011, 2'b11);
    check("prog2_idx", 32'(mc_if.prog_idx), 32'd2);
    cyc();
    set_ins(1'b1, 3'b000, 2'b00);
    check("halt2_done", 32'(mc_if.done), 32'd1);
    check("halt2_all_done", 32'(mc_if.all_done), 32'd1);
    check("halt2_prog", 32'(mc_if.prog_idx), 32'd2);

    // 4th start wraps; start held high afterwards
    cyc();
    check("wrap_prog", 32'(mc_if.prog_idx), 32'd0);
    check("wrap_all_done", 32'(mc_if.all_done), 32'd0);
    check("wrap_busy", 32'(mc_if.busy), 32'd1);
    cyc();
    set_ins(1'b1, 3'b011, 2'b11);
    check("held_run_prog", 32'(mc_if.prog_idx), 32'd0);
    cyc();
    set_ins(1'b1, 3'b000, 2'b00);
    check("held_halt_done", 32'(mc_if.done), 32'd1);
    check("held_halt_prog", 32'(mc_if.prog_idx), 32'd0);
    cyc();
    check("held_adv_prog", 32'(mc_if.prog_idx), 32'd1);
    cyc();
    cyc();
    check("held_one_adv", 32'(mc_if.prog_idx), 32'd1);
    check("held_still_run", 32'(mc_if.busy), 32'd1);
    set_ins(1'b0, 3'b000, 2'b00);

    // T6: reset during the 2nd MEM cycle of a load
    set_ins(1'b0, 3'b011, 2'b00);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_mem_strobes", 32'(strobes()), 32'd0);
    cyc();
    check("rst_mem_busy", 32'(mc_if.busy), 32'd0);
    check("rst_mem_done", 32'(mc_if.done), 32'd0);
    check("rst_mem_prog", 32'(mc_if.prog_idx), 32'd0);
    check("rst_mem_strobes2", 32'(strobes()), 32'd0);
    cyc();
    rst_n = 1'b1;
    set_ins(1'b0, 3'b000, 2'b00);
    check("post_rst_idle", 32'(strobes()), 32'd0);
    cyc();
    check("post_rst_idle2", 32'(strobes()), 32'd0);
    check("post_rst_busy", 32'(mc_if.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
